// File: rtl/int_arbiter.sv
// int_arbiter: multi-source interrupt arbiter with M/S delegation and an issue/reply handshake to the CPU
module int_arbiter #(
  parameter int NSRC   = 4,
  parameter int CODE_W = 4,
  parameter bit RR     = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSRC-1:0]          src_ip,
  input  logic [NSRC-1:0]          src_ie,
  input  logic [NSRC-1:0]          src_deleg,
  input  logic [NSRC*CODE_W-1:0]   src_code,
  input  logic                     mstatus_mie,
  input  logic                     mstatus_sie,
  input  logic [1:0]               mode,
  output logic                     interrupt,
  input  logic                     int_reply,
  output logic [31:0]              int_cause,
  output logic                     int_to_s,
  output logic [NSRC-1:0]          src_reply
);
  localparam int IW = NSRC > 1 ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, REPLY, END} state_e;

  state_e            state_q, state_d;
  logic [NSRC-1:0]   elig, elig_q, srep_q, srep_d;
  logic              rep_q, irq_q, irq_d, dlg_q, dlg_d, to_s_q, to_s_d;
  logic              m_en, s_en;
  logic [IW-1:0]     win, win_q, win_d, rr_q, rr_d;
  logic [31:0]       cause_q, cause_d;

  function automatic int wrap(input int v);
    return v >= NSRC ? v - NSRC : v;
  endfunction

  assign m_en = mode != 2'b11 || mstatus_mie;
  assign s_en = mode == 2'b00 || (mode == 2'b01 && mstatus_sie);
  assign elig = src_ip & src_ie & ((src_deleg & {NSRC{s_en}}) | (~src_deleg & {NSRC{m_en}}));

  assign interrupt = irq_q;
  assign int_cause = cause_q;
  assign int_to_s  = to_s_q;
  assign src_reply = srep_q;

  // Winner search: first eligible index at or after the start point; scanning downward lets the nearest one win
  always_comb begin
    win = '0;
    for (int k = NSRC - 1; k >= 0; k--)
      if (elig_q[IW'(wrap((RR ? int'(rr_q) : 0) + k))]) win = IW'(wrap((RR ? int'(rr_q) : 0) + k));
  end

  // Handshake sequencing: latch the winner, raise the request, wait for the CPU reply, then one dead cycle
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    dlg_d   = dlg_q;
    rr_d    = rr_q;
    irq_d   = irq_q;
    cause_d = cause_q;
    to_s_d  = to_s_q;
    srep_d  = srep_q;
    case (state_q)
      IDLE: if (|elig_q) begin
        win_d   = win;
        dlg_d   = src_deleg[win];
        state_d = ISSUE;
      end
      ISSUE: begin
        irq_d   = 1'b1;
        cause_d = {1'b1, {(31-CODE_W){1'b0}}, src_code[int'(win_q)*CODE_W +: CODE_W]};
        to_s_d  = dlg_q;
        srep_d  = NSRC'(1) << win_q;
        rr_d    = RR ? IW'(wrap(int'(win_q) + 1)) : rr_q;
        state_d = REPLY;
      end
      REPLY: begin
        srep_d = '0;
        if (rep_q) begin
          irq_d   = 1'b0;
          state_d = END;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, outputs and the eligibility/reply sample registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      elig_q  <= '0;
      rep_q   <= 1'b0;
      win_q   <= '0;
      dlg_q   <= 1'b0;
      rr_q    <= '0;
      irq_q   <= 1'b0;
      cause_q <= '0;
      to_s_q  <= 1'b0;
      srep_q  <= '0;
    end else begin
      state_q <= state_d;
      elig_q  <= elig;
      rep_q   <= int_reply;
      win_q   <= win_d;
      dlg_q   <= dlg_d;
      rr_q    <= rr_d;
      irq_q   <= irq_d;
      cause_q <= cause_d;
      to_s_q  <= to_s_d;
      srep_q  <= srep_d;
    end
  end
endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter: fixed-priority and round-robin arbiters driven in parallel against a timestamp model
module tb_int_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  src_ip = '0, src_ie = 4'hF, src_deleg = '0;
  logic [15:0] src_code = {4'd9, 4'd11, 4'd7, 4'd3};
  logic        mie = 1'b1, sie = 1'b0, int_reply = 1'b0;
  logic [1:0]  mode = 2'b11;
  logic        irq[2], to_s[2];
  logic [31:0] cause[2];
  logic [3:0]  srep[2];
  int          n_chk = 0, n_err = 0;

  int          code_tab[4] = '{3, 7, 11, 9};
  logic [3:0]  pe[2], ms[2], e_now;
  logic        pr[2], mi[2], mt[2], d[2];
  logic [31:0] mc[2];
  bit          busy[2], armed = 1'b0;
  int          t_iss[2], t_free[2], w[2], ptr[2], n = 0;

  always #5 clk = ~clk;

  int_arbiter #(.NSRC(4), .CODE_W(4), .RR(1'b0)) u0 (
    .clk(clk), .rst(rst), .src_ip(src_ip), .src_ie(src_ie), .src_deleg(src_deleg),
    .src_code(src_code), .mstatus_mie(mie), .mstatus_sie(sie), .mode(mode),
    .interrupt(irq[0]), .int_reply(int_reply), .int_cause(cause[0]), .int_to_s(to_s[0]),
    .src_reply(srep[0]));

  int_arbiter #(.NSRC(4), .CODE_W(4), .RR(1'b1)) u1 (
    .clk(clk), .rst(rst), .src_ip(src_ip), .src_ie(src_ie), .src_deleg(src_deleg),
    .src_code(src_code), .mstatus_mie(mie), .mstatus_sie(sie), .mode(mode),
    .interrupt(irq[1]), .int_reply(int_reply), .int_cause(cause[1]), .int_to_s(to_s[1]),
    .src_reply(srep[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int s);
    for (int k = 0; k < 4; k++) if (v[(s + k) % 4]) return (s + k) % 4;
    return 0;
  endfunction

  // Model: a grant decided at edge n shows at n+1; a reply seen one edge after issue drops the line, next decision two edges later
  always @(posedge clk) begin
    n++;
    for (int j = 0; j < 4; j++)
      e_now[j] = src_ip[j] & src_ie[j] &
                 (src_deleg[j] ? (mode == 2'b00 || (mode == 2'b01 && sie)) : (mode != 2'b11 || mie));
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mi[i] = 0; mc[i] = '0; mt[i] = 0; ms[i] = '0; ptr[i] = 0;
        busy[i] = 0; t_iss[i] = -1; t_free[i] = n + 1; pe[i] = '0; pr[i] = 0;
      end else begin
        ms[i] = '0;
        if (n == t_iss[i]) begin
          mi[i] = 1; mc[i] = 32'h8000_0000 | 32'(code_tab[w[i]]); mt[i] = d[i];
          ms[i] = 4'(1 << w[i]);
          if (i == 1) ptr[i] = (w[i] + 1) % 4;
          busy[i] = 1;
        end else if (busy[i] && pr[i]) begin
          mi[i] = 0; busy[i] = 0; t_free[i] = n + 2;
        end else if (!busy[i] && n > t_iss[i] && n >= t_free[i] && pe[i] != 0) begin
          w[i] = pick(pe[i], i == 1 ? ptr[i] : 0); d[i] = src_deleg[w[i]]; t_iss[i] = n + 1;
        end
        pe[i] = e_now; pr[i] = int_reply;
      end
    end
    if (rst) armed = 1'b1;
  end

  // Every-cycle comparison of both arbiters against the model
  always @(negedge clk) if (armed)
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model irq u%0d", i), 32'(irq[i]), 32'(mi[i]));
      chk($sformatf("model cause u%0d", i), cause[i], mc[i]);
      chk($sformatf("model to_s u%0d", i), 32'(to_s[i]), 32'(mt[i]));
      chk($sformatf("model srep u%0d", i), 32'(srep[i]), 32'(ms[i]));
    end

  task automatic step(input int k = 1);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_lvl(input logic v);
    for (int c = 0; c < 20 && irq[0] !== v; c++) step();
    chk("wait irq level", 32'(irq[0]), 32'(v));
  endtask

  task automatic handshake();
    int_reply = 1'b1;
    step();
    int_reply = 1'b0;
    wait_lvl(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    step(2);
    chk("reset irq", 32'(irq[0]), 0);
    chk("reset cause", cause[0], 0);
    chk("reset srep", 32'(srep[0]), 0);
    rst = 1'b0;
    src_ip = 4'b0110;
    step(2);
    chk("fp latency E1 irq", 32'(irq[0]), 0);
    step();
    chk("fp irq E2", 32'(irq[0]), 1);
    chk("fp cause src1", cause[0], 32'h8000_0007);
    chk("fp srep src1", 32'(srep[0]), 32'h2);
    chk("rr srep src1", 32'(srep[1]), 32'h2);
    src_ip = 4'b0100;
    step();
    chk("srep one cycle", 32'(srep[0]), 0);
    step(2);
    int_reply = 1'b1;
    step();
    int_reply = 1'b0;
    chk("irq held at R", 32'(irq[0]), 1);
    step();
    chk("irq low R+1", 32'(irq[0]), 0);
    chk("cause holds", cause[0], 32'h8000_0007);
    step(2);
    chk("no rise R+3", 32'(irq[0]), 0);
    step();
    chk("rise R+4", 32'(irq[0]), 1);
    chk("fp cause src2", cause[0], 32'h8000_000B);
    chk("fp srep src2", 32'(srep[0]), 32'h4);
    src_ip = '0;
    handshake();
    step(3);

    do_reset();
    src_ip = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_lvl(1'b1);
      chk($sformatf("rr order %0d", k), 32'(srep[1]), 32'(1 << (k % 4)));
      chk($sformatf("fp stays src0 %0d", k), 32'(srep[0]), 32'h1);
      step();
      handshake();
    end
    src_ip = '0;
    step(3);

    do_reset();
    src_deleg = 4'b1000;
    src_ip = 4'b1000;
    step(6);
    chk("deleg blocked in M", 32'(irq[0]), 0);
    mode = 2'b01;
    sie = 1'b1;
    wait_lvl(1'b1);
    chk("deleg to_s", 32'(to_s[0]), 1);
    chk("deleg cause", cause[0], 32'h8000_0009);
    sie = 1'b0;
    handshake();
    step(6);
    chk("deleg blocked sie=0", 32'(irq[0]), 0);

    src_deleg = '0;
    src_ip = 4'b0001;
    mie = 1'b0;
    wait_lvl(1'b1);
    chk("non-deleg in S to_s", 32'(to_s[0]), 0);
    chk("non-deleg cause", cause[0], 32'h8000_0003);
    mode = 2'b11;
    handshake();
    step(6);
    chk("M mie=0 blocked", 32'(irq[0]), 0);
    src_ip = '0;
    mie = 1'b1;
    step(3);

    int_reply = 1'b1;
    step();
    int_reply = 1'b0;
    step(3);
    chk("idle reply ignored", 32'(irq[0]), 0);
    src_ip = 4'b0100;
    step(2);
    chk("drop test E1", 32'(irq[0]), 0);
    src_ip = '0;
    step();
    chk("latched issue E2", 32'(irq[0]), 1);
    chk("latched cause", cause[0], 32'h8000_000B);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("hold high %0d", k), 32'(irq[0]), 1);
    end
    int_reply = 1'b1;
    step();
    int_reply = 1'b0;
    chk("hold at R", 32'(irq[0]), 1);
    step();
    chk("fall R+1", 32'(irq[0]), 0);
    step(4);

    src_ip = 4'b0010;
    wait_lvl(1'b1);
    step();
    rst = 1'b1;
    step();
    chk("rst irq", 32'(irq[0]), 0);
    chk("rst cause", cause[0], 0);
    chk("rst srep", 32'(srep[0]), 0);
    chk("rst to_s", 32'(to_s[1]), 0);
    rst = 1'b0;
    step(2);
    chk("post-rst no early", 32'(irq[0]), 0);
    step();
    chk("post-rst reissue", 32'(irq[0]), 1);
    chk("post-rst cause", cause[0], 32'h8000_0007);
    src_ip = '0;
    handshake();
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
